// File: rtl/demux1to4_out_port.sv
// Purpose : routes one core write (din, sel) into one of four registered output ports held until acked.
// Latency : an accepted write shows on o_port_data/o_port_valid one cycle later.
// Backpressure: o_stall (combinational) is high while the selected port is full and not being acked.
//
// Ports:
//   i_clk, i_rst_n   clock; synchronous active-low reset
//   i_wr_en          core requests a write this cycle
//   i_sel            destination port 0..3
//   i_din            data word to store
//   o_stall          write refused, core must hold its request
//   o_port_data      port k data at [k*DATA_W +: DATA_W]
//   o_port_valid     port k holds unconsumed data
//   i_port_ack       consumer k takes its data this cycle
//   o_busy           any port holds unconsumed data
module demux1to4_out_port #(
  parameter int DATA_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [1:0]          i_sel,
  input  logic [DATA_W-1:0]   i_din,
  output logic                o_stall,
  output logic [4*DATA_W-1:0] o_port_data,
  output logic [3:0]          o_port_valid,
  input  logic [3:0]          i_port_ack,
  output logic                o_busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } port_st_t;

  port_st_t          r_st       [4];
  port_st_t          w_st_nxt   [4];
  logic [DATA_W-1:0] r_data     [4];
  logic [DATA_W-1:0] w_data_nxt [4];
  logic              w_stall;
  logic              w_accept;
  logic              w_wr_k;

  // A full port can take a new word in the same cycle its consumer acks it,
  // so only a full, un-acked selected port blocks the core.
  always_comb begin
    w_stall  = i_wr_en & (r_st[i_sel] == ST_FULL) & ~i_port_ack[i_sel];
    w_accept = i_wr_en & ~w_stall;
  end

  // Per-port next state; ports are independent apart from sharing the write.
  always_comb begin
    w_wr_k = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_st_nxt[k]   = r_st[k];
      w_data_nxt[k] = r_data[k];
      w_wr_k        = w_accept & (i_sel == 2'(k));
      case (r_st[k])
        ST_EMPTY: begin
          // An ack on an empty port is meaningless and ignored.
          if (w_wr_k) begin
            w_st_nxt[k]   = ST_FULL;
            w_data_nxt[k] = i_din;
          end
        end
        ST_FULL: begin
          if (w_wr_k) begin
            // Only reachable with an ack present: back-to-back refill.
            w_st_nxt[k]   = ST_FULL;
            w_data_nxt[k] = i_din;
          end else if (i_port_ack[k]) begin
            // Drain: data keeps its last value for visibility.
            w_st_nxt[k]   = ST_EMPTY;
          end
        end
        default: begin
          w_st_nxt[k] = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_st[k]   <= ST_EMPTY;
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_st[k]   <= w_st_nxt[k];
        r_data[k] <= w_data_nxt[k];
      end
    end
  end

  always_comb begin
    o_port_data  = '0;
    o_port_valid = '0;
    for (int k = 0; k < 4; k++) begin
      o_port_data[k*DATA_W +: DATA_W] = r_data[k];
      o_port_valid[k]                 = (r_st[k] == ST_FULL);
    end
    o_busy  = |o_port_valid;
    o_stall = w_stall;
  end

endmodule

// File: tb/tb_demux1to4_out_port.sv
// Directed bench for demux1to4_out_port: a port-level reference model is checked
// every cycle, and literal expectations pin the model at each scenario.
module tb_demux1to4_out_port;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  sel;
  logic [7:0]  din;
  logic        stall;
  logic [31:0] port_data;
  logic [3:0]  port_valid;
  logic [3:0]  port_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  demux1to4_out_port #(.DATA_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_sel        (sel),
    .i_din        (din),
    .o_stall      (stall),
    .o_port_data  (port_data),
    .o_port_valid (port_valid),
    .i_port_ack   (port_ack),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each port is "holds a word or not" plus its stored word.
  logic [7:0] m_data  [4];
  logic       m_valid [4];
  bit         m_live = 0;

  function automatic logic model_stall();
    return wr_en && m_valid[sel] && !port_ack[sel];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k]  = 8'h00;
        m_valid[k] = 1'b0;
      end
      m_live = 1;
    end else if (m_live) begin
      logic st;
      st = model_stall();
      for (int k = 0; k < 4; k++) begin
        if (wr_en && !st && sel == 2'(k)) begin
          m_data[k]  = din;
          m_valid[k] = 1'b1;
        end else if (port_ack[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      logic [31:0] ed;
      logic [3:0]  ev;
      ed = {m_data[3], m_data[2], m_data[1], m_data[0]};
      ev = {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
      chk("model_data",  port_data, ed);
      chk("model_valid", {28'd0, port_valid}, {28'd0, ev});
      chk("model_busy",  {31'd0, busy}, {31'd0, |ev});
      chk("model_stall", {31'd0, stall}, {31'd0, model_stall()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; sel = 2'd0; din = 8'hFF; port_ack = 4'b0000;

    // 1. Reset with a write pending
    tick(); tick();
    rst_n = 1'b1; wr_en = 1'b0;
    chk("rst_data",  port_data, 32'h0);
    chk("rst_valid", {28'd0, port_valid}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'h0);

    // 2. Single write to port 2
    wr_en = 1'b1; sel = 2'd2; din = 8'hA5;
    #1 chk("wr_nostall", {31'd0, stall}, 32'h0);
    tick(); wr_en = 1'b0;
    chk("wr_data2",  {24'd0, port_data[23:16]}, 32'hA5);
    chk("wr_valid",  {28'd0, port_valid}, 32'h4);
    chk("wr_busy",   {31'd0, busy}, 32'h1);

    // 3. Stall on full port, then release with ack
    wr_en = 1'b1; sel = 2'd2; din = 8'h3C; port_ack = 4'b0000;
    #1 chk("stall_hi", {31'd0, stall}, 32'h1);
    tick();
    chk("stall_hold", {24'd0, port_data[23:16]}, 32'hA5);
    port_ack = 4'b0100;
    #1 chk("stall_rel", {31'd0, stall}, 32'h0);
    tick(); wr_en = 1'b0; port_ack = 4'b0000;
    chk("refill_data",  {24'd0, port_data[23:16]}, 32'h3C);
    chk("refill_valid", {28'd0, port_valid}, 32'h4);

    // 4. Drain, then ack on empty ports
    port_ack = 4'b0100;
    tick(); port_ack = 4'b0000;
    chk("drain_valid", {28'd0, port_valid}, 32'h0);
    chk("drain_data",  {24'd0, port_data[23:16]}, 32'h3C);
    chk("drain_busy",  {31'd0, busy}, 32'h0);
    port_ack = 4'b1111;
    tick(); port_ack = 4'b0000;
    chk("ack_empty_data",  port_data, 32'h003C0000);
    chk("ack_empty_valid", {28'd0, port_valid}, 32'h0);

    // 5. Parallel: drain port 0 while writing port 1
    wr_en = 1'b1; sel = 2'd0; din = 8'h11;
    tick();
    sel = 2'd1; din = 8'h22; port_ack = 4'b0001;
    #1 chk("par_nostall", {31'd0, stall}, 32'h0);
    tick(); wr_en = 1'b0; port_ack = 4'b0000;
    chk("par_valid", {28'd0, port_valid}, 32'h2);
    chk("par_d1",    {24'd0, port_data[15:8]}, 32'h22);
    chk("par_d0",    {24'd0, port_data[7:0]}, 32'h11);

    // Acks on other ports do not release a stall on port 1
    wr_en = 1'b1; sel = 2'd1; din = 8'h99; port_ack = 4'b1101;
    #1 chk("other_ack_stall", {31'd0, stall}, 32'h1);
    tick(); port_ack = 4'b0000; wr_en = 1'b0;
    chk("other_ack_hold", {24'd0, port_data[15:8]}, 32'h22);
    // Full port but no write request: never stall
    sel = 2'd1;
    #1 chk("nowr_nostall", {31'd0, stall}, 32'h0);

    // 6. Fill all ports, reset mid-operation
    wr_en = 1'b1;
    sel = 2'd0; din = 8'h40; tick();
    sel = 2'd2; din = 8'h42; tick();
    sel = 2'd3; din = 8'h43; tick();
    wr_en = 1'b0;
    chk("full_valid", {28'd0, port_valid}, 32'hF);
    chk("full_data",  port_data, 32'h43422240);
    rst_n = 1'b0; wr_en = 1'b1; sel = 2'd0; din = 8'h77; port_ack = 4'b1111;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; port_ack = 4'b0000;
    chk("mid_rst_valid", {28'd0, port_valid}, 32'h0);
    chk("mid_rst_data",  port_data, 32'h0);
    wr_en = 1'b1; sel = 2'd0; din = 8'h5A;
    #1 chk("post_rst_stall", {31'd0, stall}, 32'h0);
    tick(); wr_en = 1'b0;
    chk("post_rst_valid", {28'd0, port_valid}, 32'h1);
    chk("post_rst_data",  {24'd0, port_data[7:0]}, 32'h5A);

    // Throughput: one write per cycle with every consumer acking
    port_ack = 4'b1111; wr_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sel = 2'(i % 4);
      din = 8'(i * 8'h13 + 8'h07);
      #1 chk("tput_stall", {31'd0, stall}, 32'h0);
      tick();
    end
    wr_en = 1'b0; port_ack = 4'b0000;
    chk("tput_last", {24'd0, port_data[31:24]}, 32'(8'(11 * 8'h13 + 8'h07)));
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
